fetch_unit: RTL and testbench

Instruction fetch stage of the simple accumulator CPU, directly upstream of the controller. It owns the program counter (PC) and the instruction register (IR), and it fetches instruction words from instruction memory over a variable-latency req/ack handshake. It presents the 4-bit opcode and the operand field to the controller, and it executes the controller's LoadIR / IncPC / SelPC / LoadPC commands.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pc_unit.sv | 43 ++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode map, fetch state
// encoding and instruction field layout.
package cpu_pkg;

  // Instruction layout: op = word[DW-1 -: OP_W], operand = word[DW-OP_W-1:0]
  localparam int unsigned OP_W = 4;

  // Fetch FSM state encoding
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_VALID = 2'd2
  } fetch_state_e;

  // Opcode map
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
  localparam logic [OP_W-1:0] OP_NOR  = 4'h2;
  localparam logic [OP_W-1:0] OP_MOVR = 4'h3;
  localparam logic [OP_W-1:0] OP_MOVA = 4'h4;
  localparam logic [OP_W-1:0] OP_JZRS = 4'h5;
  localparam logic [OP_W-1:0] OP_JZIM = 4'h6;
  localparam logic [OP_W-1:0] OP_JCRS = 4'h7;
  localparam logic [OP_W-1:0] OP_JCIM = 4'h8;
  localparam logic [OP_W-1:0] OP_SHL  = 4'h9;
  localparam logic [OP_W-1:0] OP_SHR  = 4'hA;
  localparam logic [OP_W-1:0] OP_LDIM = 4'hB;
  localparam logic [OP_W-1:0] OP_HALT = 4'hC;

endpackage

// File: rtl/pc_unit.sv
// Program counter register with increment and jump-target load.
// Ports:
//   clk, CLB      clock, synchronous active-high reset
//   inc           advance PC by one (modulo 2^AW)
//   load          load the selected jump target (wins over inc)
//   sel           target select: 0 = zero-extended operand, 1 = reg_data
//   operand       immediate jump target from IR
//   reg_data      register-indirect jump target
//   pc            current PC
module pc_unit #(
  parameter int unsigned AW = 8,
  parameter int unsigned OW = 4
) (
  input  logic          clk,
  input  logic          CLB,
  input  logic          inc,
  input  logic          load,
  input  logic          sel,
  input  logic [OW-1:0] operand,
  input  logic [AW-1:0] reg_data,
  output logic [AW-1:0] pc
);

  logic [AW-1:0] pc_d, pc_q;

  // Load has priority; a simultaneous increment is dropped
  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = sel ? reg_data : AW'(operand);
    end else if (inc) begin
      pc_d = pc_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (CLB) pc_q <= '0;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns PC and IR, fetches from instruction memory
// over a variable-latency req/ack handshake.
// Ports:
//   clk, CLB              clock, synchronous active-high reset
//   LoadIR/IncPC/SelPC/LoadPC  controller commands
//   reg_data              register-indirect jump target
//   imem_req/imem_addr    fetch request and address (registered)
//   imem_ack/imem_rdata   memory response
//   op/operand            IR fields to the controller
//   ir_valid              IR holds an unconsumed completed fetch
//   pc                    current PC
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic               clk,
  input  logic               CLB,
  input  logic               LoadIR,
  input  logic               IncPC,
  input  logic               SelPC,
  input  logic               LoadPC,
  input  logic [AW-1:0]      reg_data,
  output logic               imem_req,
  output logic [AW-1:0]      imem_addr,
  input  logic               imem_ack,
  input  logic [DW-1:0]      imem_rdata,
  output logic [OP_W-1:0]    op,
  output logic [DW-OP_W-1:0] operand,
  output logic               ir_valid,
  output logic [AW-1:0]      pc
);

  localparam int unsigned OW = DW - OP_W;

  fetch_state_e  state_q, state_d;
  logic [DW-1:0] ir_q, ir_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          valid_q, valid_d;

  pc_unit #(.AW(AW), .OW(OW)) u_pc (
    .clk      (clk),
    .CLB      (CLB),
    .inc      (IncPC),
    .load     (LoadPC),
    .sel      (SelPC),
    .operand  (operand),
    .reg_data (reg_data),
    .pc       (pc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (CLB) state_q <= FETCH_IDLE;
    else     state_q <= state_d;
  end

  // Next state: LoadIR starts a fetch except while one is outstanding
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH_IDLE:  if (LoadIR)   state_d = FETCH_WAIT;
      FETCH_WAIT:  if (imem_ack) state_d = FETCH_VALID;
      FETCH_VALID: if (LoadIR)   state_d = FETCH_WAIT;
      default:                   state_d = FETCH_IDLE;
    endcase
  end

  // Output/datapath next values; acks outside WAIT are ignored
  always_comb begin
    ir_d    = ir_q;
    req_d   = req_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    unique case (state_q)
      FETCH_IDLE, FETCH_VALID: begin
        if (LoadIR) begin
          req_d   = 1'b1;
          addr_d  = pc;
          valid_d = 1'b0;
        end
      end
      FETCH_WAIT: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      ir_q    <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ir_q    <= ir_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = valid_q;
  assign op        = ir_q[DW-1 -: OP_W];
  assign operand   = ir_q[OW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// jump/fetch transactions checked against a transaction-level model.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       CLB, LoadIR, IncPC, SelPC, LoadPC;
  logic [7:0] reg_data;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [3:0] op;
  logic [3:0] operand;
  logic       ir_valid;
  logic [7:0] pc;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_pc;
  logic [7:0] exp_ir;

  always #5 clk = ~clk;

  fetch_unit #(.AW(8), .DW(8)) dut (
    .clk        (clk),
    .CLB        (CLB),
    .LoadIR     (LoadIR),
    .IncPC      (IncPC),
    .SelPC      (SelPC),
    .LoadPC     (LoadPC),
    .reg_data   (reg_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .op         (op),
    .operand    (operand),
    .ir_valid   (ir_valid),
    .pc         (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge; outputs are sampled and inputs changed 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    LoadIR = 1'b0; IncPC = 1'b0; SelPC = 1'b0; LoadPC = 1'b0;
    imem_ack = 1'b0;
  endtask

  // Jump through reg_data
  task automatic jump_reg(input logic [7:0] target);
    LoadPC = 1'b1; SelPC = 1'b1; reg_data = target;
    tick();
    LoadPC = 1'b0; SelPC = 1'b0;
    exp_pc = target;
    chk("jump_reg_pc", 32'(pc), 32'(exp_pc));
  endtask

  // One fetch at the current PC: k wait cycles, IncPC in the first `incs`
  // of them, optional extra LoadIR during WAIT (must be ignored).
  task automatic fetch(input int k, input int incs, input bit extra);
    logic [7:0] addr;
    logic [7:0] old_ir;
    addr   = exp_pc;
    old_ir = exp_ir;
    LoadIR = 1'b1;
    tick();
    LoadIR = 1'b0;
    chk("start_req", 32'(imem_req), 32'd1);
    chk("start_addr", 32'(imem_addr), 32'(addr));
    chk("start_valid", 32'(ir_valid), 32'd0);
    for (int i = 0; i < k; i++) begin
      IncPC  = (i < incs);
      LoadIR = extra && (i == 0);
      tick();
      if (i < incs) exp_pc = exp_pc + 8'd1;
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_addr", 32'(imem_addr), 32'(addr));
      chk("wait_ir_hold", 32'({op, operand}), 32'(old_ir));
    end
    IncPC = 1'b0; LoadIR = 1'b0;
    imem_ack = 1'b1; imem_rdata = mem[addr];
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom();
    exp_ir = mem[addr];
    chk("done_valid", 32'(ir_valid), 32'd1);
    chk("done_ir", 32'({op, operand}), 32'(exp_ir));
    chk("done_req", 32'(imem_req), 32'd0);
    chk("done_pc", 32'(pc), 32'(exp_pc));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
    mem[8'h00] = 8'h15;
    mem[8'h20] = 8'h7A;
    idle_inputs();
    reg_data = 8'h00; imem_rdata = 8'h00;

    // Reset values
    CLB = 1'b1;
    tick();
    tick();
    CLB = 1'b0;
    exp_pc = 8'h00; exp_ir = 8'h00;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_ir", 32'({op, operand}), 32'd0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Ack outside WAIT is ignored
    imem_ack = 1'b1; imem_rdata = 8'hEE;
    tick();
    imem_ack = 1'b0;
    chk("idle_ack_ir", 32'({op, operand}), 32'd0);
    chk("idle_ack_valid", 32'(ir_valid), 32'd0);

    // Minimum latency fetch of mem[0] = 8'h15
    fetch(0, 0, 1'b0);
    chk("first_op", 32'(op), 32'h1);
    chk("first_operand", 32'(operand), 32'h5);
    chk("first_addr", 32'(imem_addr), 32'h0);

    // Ack in VALID ignored
    imem_ack = 1'b1; imem_rdata = 8'hEE;
    tick();
    imem_ack = 1'b0;
    chk("valid_ack_ir", 32'({op, operand}), 32'h15);
    chk("valid_ack_valid", 32'(ir_valid), 32'd1);

    // Delayed ack, IncPC during WAIT, second LoadIR ignored
    fetch(3, 1, 1'b1);
    chk("delayed_pc", 32'(pc), 32'd1);
    tick();
    chk("no_refetch_req", 32'(imem_req), 32'd0);
    chk("no_refetch_valid", 32'(ir_valid), 32'd1);

    // PC wrap
    jump_reg(8'hFF);
    IncPC = 1'b1;
    tick();
    IncPC = 1'b0;
    exp_pc = 8'h00;
    chk("wrap_pc", 32'(pc), 32'd0);

    // LoadPC beats IncPC, immediate target from operand 4'hA
    jump_reg(8'h20);
    fetch(1, 0, 1'b0);
    LoadPC = 1'b1; IncPC = 1'b1; SelPC = 1'b0;
    tick();
    idle_inputs();
    exp_pc = 8'h0A;
    chk("loadpc_prio", 32'(pc), 32'h0A);

    // Register-indirect jump then fetch from it
    jump_reg(8'h3C);
    fetch(2, 0, 1'b0);
    chk("jump_fetch_addr", 32'(imem_addr), 32'h3C);

    // Reset mid-WAIT, then a late ack must be ignored
    LoadIR = 1'b1;
    tick();
    LoadIR = 1'b0;
    chk("pre_rst_req", 32'(imem_req), 32'd1);
    CLB = 1'b1;
    tick();
    CLB = 1'b0;
    exp_pc = 8'h00; exp_ir = 8'h00;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_ir", 32'({op, operand}), 32'd0);
    chk("mid_rst_valid", 32'(ir_valid), 32'd0);
    imem_ack = 1'b1; imem_rdata = 8'hEE;
    tick();
    imem_ack = 1'b0;
    chk("late_ack_ir", 32'({op, operand}), 32'd0);
    chk("late_ack_valid", 32'(ir_valid), 32'd0);
    fetch(1, 0, 1'b0);

    // Randomized jump + fetch transactions
    for (int t = 0; t < 40; t++) begin
      int k;
      int incs;
      if ($urandom_range(0, 1) == 1) begin
        jump_reg(8'($urandom()));
      end else begin
        // Immediate jump; an accompanying IncPC must be dropped
        LoadPC = 1'b1; SelPC = 1'b0; IncPC = 1'($urandom());
        tick();
        idle_inputs();
        exp_pc = {4'h0, exp_ir[3:0]};
        chk("rnd_imm_pc", 32'(pc), 32'(exp_pc));
      end
      k    = $urandom_range(0, 4);
      incs = $urandom_range(0, k);
      fetch(k, incs, 1'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
